// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline: opcodes, IR field positions,
// the link register index and the stall-controller state encoding.
package pipe_pkg;

  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b00101;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 18;
  localparam int RS2_HI  = 17;
  localparam int RS2_LO  = 14;

  localparam logic [3:0] RA = 4'b1111;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    MEM_WAIT
  } state_t;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/src_decode.sv
// Source-operand decode for one instruction register: which register fields
// are actually read, and their indices. Shared by the stall and forwarding logic.
module src_decode
  import pipe_pkg::*;
(
  input  logic [31:0] ir,
  output logic        rs1_valid,
  output logic        rs2_valid,
  output logic        rd_is_src,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd
);

  logic [4:0] op;

  assign op  = opcode_of(ir);
  assign rs1 = ir[RS1_HI:RS1_LO];
  assign rs2 = ir[RS2_HI:RS2_LO];

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rs1_valid = 1'b1;
    case (op)
      OP_NOP, OP_NOT, OP_MOV, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET:
        rs1_valid = 1'b0;
      default:
        rs1_valid = 1'b1;
    endcase
  end

  assign rs2_valid = (!ir[IMM_BIT] && rs1_valid) || (op == OP_CMP);

  // ret reads the link register; it is reported through the rd-as-source path.
  assign rd_is_src = (op == OP_ST) || (op == OP_RET);
  assign rd        = (op == OP_RET) ? RA : ir[RD_HI:RD_LO];

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencing: stage enables, flush/bubble and data-memory handshake
// for load-use, taken-branch and multi-cycle memory hazards.
module pipeline_stall_controller
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      of_ir,
  input  logic [31:0]      ex_ir,
  input  logic [31:0]      ma_ir,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic [4:0]       stage_en,
  output logic             if_of_flush,
  output logic             of_ex_bubble,
  output logic             mem_req,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;

  logic       of_rs1_valid, of_rs2_valid, of_rd_is_src;
  logic [3:0] of_rs1, of_rs2, of_rd;
  logic [4:0] ex_op, ma_op;
  logic [3:0] ex_rd;
  logic       lu, mop;
  logic [4:0] run_en;
  logic       run_flush, run_bubble;
  logic       unused_ir_bits;

  src_decode u_of_decode (
    .ir        (of_ir),
    .rs1_valid (of_rs1_valid),
    .rs2_valid (of_rs2_valid),
    .rd_is_src (of_rd_is_src),
    .rs1       (of_rs1),
    .rs2       (of_rs2),
    .rd        (of_rd)
  );

  assign ex_op = opcode_of(ex_ir);
  assign ma_op = opcode_of(ma_ir);
  assign ex_rd = ex_ir[RD_HI:RD_LO];
  assign unused_ir_bits = ^{ex_ir[IMM_BIT], ex_ir[RS1_HI:0], ma_ir[IMM_BIT:0]};

  assign lu  = (ex_op == OP_LD) &&
               ((of_rs1_valid && (ex_rd == of_rs1)) ||
                (of_rs2_valid && (ex_rd == of_rs2)) ||
                (of_rd_is_src && (ex_rd == of_rd)));
  assign mop = (ma_op == OP_LD) || (ma_op == OP_ST);

  // Branch outranks load-use: the dependent OF instruction is squashed anyway.
  always_comb begin
    run_en     = 5'b11111;
    run_flush  = 1'b0;
    run_bubble = 1'b0;
    if (branch_taken) begin
      run_flush  = 1'b1;
      run_bubble = 1'b1;
    end else if (lu) begin
      run_en     = 5'b11100;
      run_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_en     = 5'b00000;
    if_of_flush  = 1'b0;
    of_ex_bubble = 1'b0;
    mem_req      = 1'b0;
    unique case (state_q)
      INIT: begin
        if_of_flush  = 1'b1;
        of_ex_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        mem_req = mop;
        if (mop && !mem_ack) begin
          state_d = MEM_WAIT;
        end else begin
          stage_en     = run_en;
          if_of_flush  = run_flush;
          of_ex_bubble = run_bubble;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d      = RUN;
          stage_en     = run_en;
          if_of_flush  = run_flush;
          of_ex_bubble = run_bubble;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= INIT;
      wait_cnt_q      <= '0;
      mem_timeout_err <= 1'b0;
      stall_cycles    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == RUN && state_d == MEM_WAIT) begin
        wait_cnt_q <= '0;
      end else if (state_q == MEM_WAIT && wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end

      // Flag rises on the edge where the wait counter reaches its limit.
      if (state_q == MEM_WAIT && wait_cnt_q >= WAIT_LAST) begin
        mem_timeout_err <= 1'b1;
      end

      if (!stage_en[0] && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequencing controller for the five-stage pipeline (IF, OF, EX, MA, RW). It consumes the OF/EX/MA instruction registers, the EX-stage branch outcome and the data-memory acknowledge. From these it drives the per-stage pipeline-register enables, flush/bubble controls and the data-memory request. It covers the hazards the forwarding units cannot resolve (load-use, taken branches, multi-cycle memory) and keeps a stall-cycle counter and a memory-timeout flag.

## Interface
- MEM_TIMEOUT, default 64: max cycles in MEM_WAIT before `mem_timeout_err` sets.
- CNT_W, default 16: width of `stall_cycles`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- of_ir  in  32  OF-stage IR.
- ex_ir  in  32  EX-stage IR.
- ma_ir  in  32  MA-stage IR.
- branch_taken  in  1  EX-stage branch unit: branch/call/ret in EX is taken.
- mem_ack  in  1  data memory completed current request (1-cycle pulse).
- stage_en  out  5  register enables: [0] PC, [1] IF/OF, [2] OF/EX, [3] EX/MA, [4] MA/RW.
- if_of_flush  out  1  load NOP into IF/OF.
- of_ex_bubble  out  1  load NOP into OF/EX.
- mem_req  out  1  data-memory request for the ld/st in MA.
- mem_timeout_err  out  1  sticky; cleared only by reset.
- stall_cycles  out  CNT_W  count of cycles with stage_en[0]==0; saturates at all-ones.

## Operation
- Field decode: opcode [31:27], imm [26], rd [25:22], rs1 [21:18], rs2 [17:14]. ld=01110, st=01111, nop=01101, b=10010, beq=10000, bgt=10001, call=10011, ret=10100, not=01000, mov=01001. ra=4'b1111.
- OF sources:
  - rs1 is valid unless the opcode is nop, not, mov, b, beq, bgt, call or ret.
  - rs2 is valid when imm==0 and rs1 is valid, or when the opcode is cmp (00101).
  - st additionally reads rd. ret reads ra.
- Load-use hazard (`lu`): ex opcode==ld AND ex rd equals any valid OF source.
- Memory op (`mop`): ma opcode is ld or st.
- States: INIT, RUN, MEM_WAIT.
- INIT (entered on reset, lasts 1 cycle):
  - stage_en=5'b00000; if_of_flush=1; of_ex_bubble=1.
  - Next state is RUN.
- RUN, priority order:
  - (1) mop and !mem_ack: mem_req=1, stage_en=0, go to MEM_WAIT.
  - (2) branch_taken: stage_en=5'b11111, if_of_flush=1, of_ex_bubble=1.
  - (3) lu: stage_en=5'b11100, of_ex_bubble=1.
  - (4) otherwise stage_en=5'b11111.
  - When mop and mem_ack arrive in the same cycle, mem_req=1 and rules (2)–(4) apply that cycle.
- MEM_WAIT:
  - mem_req=1, stage_en=0, no flush or bubble.
  - A wait counter increments each cycle.
  - On mem_ack: return to RUN. That cycle applies rules (2)–(4) with mop treated as satisfied.
  - When the wait counter reaches MEM_TIMEOUT, set mem_timeout_err. Remain in MEM_WAIT.
- branch_taken during MEM_WAIT is ignored. EX is frozen, so the branch re-presents on return to RUN.
- Branch beats load-use, because the OF consumer is squashed anyway.

## Timing
- Reset values:
  - stage_en=0, if_of_flush=1, of_ex_bubble=1 (INIT).
  - mem_req=0, mem_timeout_err=0, stall_cycles=0, wait counter=0.
- All outputs are combinational from state plus inputs. The state, wait counter, stall_cycles and err are registered on the rising edge of clk.
- Stall and flush latency:
  - Load-use costs exactly 1 bubble cycle. In the next cycle the ld has reached MA, so lu clears.
  - A taken branch costs 2 squashed slots.
  - A memory op costs N extra cycles when mem_ack arrives N cycles after the request.
- The wait counter clears on entry to MEM_WAIT and saturates at MEM_TIMEOUT.
- stall_cycles increments in every cycle where stage_en[0]==0, including INIT. It holds at max.
- Reset mid-MEM_WAIT: the state goes to INIT immediately, and mem_req drops asynchronously.

## Structure
- Shared package `pipe_pkg`:
  - opcode localparams (ld, st, nop, b, beq, bgt, call, ret, not, mov, cmp).
  - field-slice constants.
  - state enum {INIT, RUN, MEM_WAIT}.
  - RA constant.
- One sub-module, `src_decode`: combinational. Input is an IR; outputs are rs1_valid, rs2_valid, rd_is_src, rs1, rs2, rd. It is instantiated once for OF and is reusable by the forwarding units.

## Test plan
- Reset release with every IR=NOP (0x68000000) → cycle 0: stage_en=00000, if_of_flush=1, of_ex_bubble=1; cycle 1: stage_en=11111; stall_cycles=1.
- ex_ir = ld r3 (rd=3), of_ir = add rd=5, rs1=3, rs2=7, imm=0 → one cycle of stage_en=11100 and of_ex_bubble=1; the next cycle (ex_ir=NOP) gives stage_en=11111.
- ex_ir = ld r3, of_ir = add rs1=3, imm=1, with branch_taken=1 in the same cycle → stage_en=11111, if_of_flush=1, of_ex_bubble=1.
- ma_ir = st, mem_ack 3 cycles later → mem_req=1 for 4 cycles, stage_en=0 for 3 cycles then 11111, stall_cycles +3.
- MEM_TIMEOUT=4, ma_ir = ld, no mem_ack → mem_timeout_err=1 after 4 wait cycles. The flag stays 1 after a later mem_ack and clears only on reset_n=0.
- reset_n asserted while in MEM_WAIT → mem_req=0 immediately, state INIT, all counters 0.
